pma_tx_serializer: RTL and testbench

Serializer stage directly downstream of the PCS transmit path. It takes the 10-bit 8b/10b symbol `Data_In_PMA` and shifts it out one bit per `Bit_Rate_CLK` cycle, MSB (bit `a`) first. It manages electrical-idle entry and exit on word boundaries, applies optional polarity inversion, and monitors running disparity of the transmitted symbols.

---
 rtl/pma_tx_serializer.sv | 129 ++++++++++++
 tb/tb_pma_tx_serializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pma_tx_serializer.sv
// Transmit PMA serializer: shifts 10-bit 8b/10b symbols out MSB first on word
// boundaries, with electrical idle, polarity inversion and running-disparity checking.
module pma_tx_serializer #(
    parameter int   WORD_W     = 10,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              Bit_Rate_CLK,
    input  logic              Reset_n,
    input  logic [WORD_W-1:0] Data_In_PMA,
    input  logic              Data_Valid,
    input  logic              TxElecIdle,
    input  logic              Tx_Polarity,
    output logic              TX_Out,
    output logic              TX_Idle,
    output logic              Word_Start,
    output logic              Disp_Err
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int PC_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [PC_W-1:0]  PC_HALF  = PC_W'(WORD_W / 2);

    typedef enum logic {
        ST_IDLE,
        ST_SERIAL
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-2:0]   shreg_q, shreg_d;
    logic                pol_q, pol_d;
    logic                rd_q, rd_d;
    logic                tx_q, tx_d;
    logic                idle_q, idle_d;
    logic                ws_q, ws_d;
    logic                err_q, err_d;

    logic                capture;
    logic                load_data;
    logic [PC_W-1:0]     ones;

    assign capture   = (cnt_q == CNT_LAST);
    // Electrical idle overrides a valid symbol presented on the same boundary.
    assign load_data = Data_Valid && !TxElecIdle;

    always_comb begin
        ones = '0;
        for (int i = 0; i < WORD_W; i++) begin
            ones = ones + PC_W'(Data_In_PMA[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = capture ? '0 : cnt_q + CNT_W'(1);
        shreg_d = {shreg_q[WORD_W-3:0], IDLE_LEVEL};
        tx_d    = shreg_q[WORD_W-2] ^ pol_q;
        pol_d   = pol_q;
        rd_d    = rd_q;
        idle_d  = idle_q;
        err_d   = err_q;
        ws_d    = capture;

        if (capture) begin
            case (state_q)
                ST_IDLE:   state_d = load_data ? ST_SERIAL : ST_IDLE;
                ST_SERIAL: state_d = load_data ? ST_SERIAL : ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase

            if (load_data) begin
                tx_d    = Data_In_PMA[WORD_W-1] ^ Tx_Polarity;
                shreg_d = Data_In_PMA[WORD_W-2:0];
                pol_d   = Tx_Polarity;
                idle_d  = 1'b0;
                if (ones == PC_HALF) begin
                    err_d = 1'b0;
                end else if (ones == PC_HALF + PC_W'(1)) begin
                    err_d = rd_q;
                    rd_d  = 1'b1;
                end else if (ones == PC_HALF - PC_W'(1)) begin
                    err_d = !rd_q;
                    rd_d  = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                // Idle words carry no polarity and restart disparity at RD-.
                tx_d    = IDLE_LEVEL;
                shreg_d = {(WORD_W-1){IDLE_LEVEL}};
                pol_d   = 1'b0;
                idle_d  = 1'b1;
                err_d   = 1'b0;
                rd_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge Bit_Rate_CLK) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= {(WORD_W-1){IDLE_LEVEL}};
            pol_q   <= 1'b0;
            rd_q    <= 1'b0;
            tx_q    <= IDLE_LEVEL;
            idle_q  <= 1'b1;
            ws_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            pol_q   <= pol_d;
            rd_q    <= rd_d;
            tx_q    <= tx_d;
            idle_q  <= idle_d;
            ws_q    <= ws_d;
            err_q   <= err_d;
        end
    end

    assign TX_Out     = tx_q;
    assign TX_Idle    = idle_q;
    assign Word_Start = ws_q;
    assign Disp_Err   = err_q;

endmodule

// File: tb/tb_pma_tx_serializer.sv
// Self-checking bench for pma_tx_serializer: each word queues its ten expected
// {TX_Out, TX_Idle, Word_Start, Disp_Err} tuples, popped and compared per bit period.
module tb_pma_tx_serializer;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic [9:0] Data_In_PMA;
    logic       Data_Valid;
    logic       TxElecIdle;
    logic       Tx_Polarity;
    logic       TX_Out;
    logic       TX_Idle;
    logic       Word_Start;
    logic       Disp_Err;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    pma_tx_serializer #(.WORD_W(10), .IDLE_LEVEL(1'b0)) dut (
        .Bit_Rate_CLK(clk),
        .Reset_n     (Reset_n),
        .Data_In_PMA (Data_In_PMA),
        .Data_Valid  (Data_Valid),
        .TxElecIdle  (TxElecIdle),
        .Tx_Polarity (Tx_Polarity),
        .TX_Out      (TX_Out),
        .TX_Idle     (TX_Idle),
        .Word_Start  (Word_Start),
        .Disp_Err    (Disp_Err)
    );

    // Called in the cnt==9 bit period: present inputs for the coming capture edge
    // and queue the ten bit periods that follow it.
    task automatic drive_word(input logic [9:0] data, input logic dv, input logic ei,
                              input logic pol, input logic exp_err);
        Data_In_PMA = data;
        Data_Valid  = dv;
        TxElecIdle  = ei;
        Tx_Polarity = pol;
        for (int i = 0; i < 10; i++) begin
            if (dv && !ei)
                exp_q.push_back({data[9-i] ^ pol, 1'b0, (i == 0), exp_err});
            else
                exp_q.push_back({1'b0, 1'b1, (i == 0), 1'b0});
        end
    endtask

    task automatic next_bit(output logic [3:0] e, output logic [3:0] o);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) e = 4'bxxxx;
        else e = exp_q.pop_front();
        o = {TX_Out, TX_Idle, Word_Start, Disp_Err};
    endtask

    task automatic test_reset();
        logic [3:0] e, o;
        Reset_n = 1'b0; Data_Valid = 1'b0; TxElecIdle = 1'b0;
        Tx_Polarity = 1'b0; Data_In_PMA = 10'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = {TX_Out, TX_Idle, Word_Start, Disp_Err};
        checks++;
        if (o !== 4'b0100) begin
            errors++;
            $display("FAIL reset_values: got tx/idle/ws/err=%b required 0100", o);
        end
        Reset_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            o = {TX_Out, TX_Idle, Word_Start, Disp_Err};
            checks++;
            if (o !== 4'b0100) begin
                errors++;
                $display("FAIL reset_release cycle%0d: got %b required 0100", i, o);
            end
        end
        for (int w = 0; w < 2; w++) begin
            drive_word(10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) begin
                next_bit(e, o);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL idle_words w%0d bit%0d: got %b required %b", w, i, o, e);
                end
            end
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single();
        logic [3:0] e, o;
        logic [9:0] words[2] = '{10'h0FA, 10'h000};
        logic       valid[2] = '{1'b1, 1'b0};
        for (int w = 0; w < 2; w++) begin
            drive_word(words[w], valid[w], 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) begin
                next_bit(e, o);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL single w%0d bit%0d: got %b required %b", w, i, o, e);
                end
            end
        end
        $display("test_single done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_back_to_back();
        logic [3:0] e, o;
        logic [9:0] words[4] = '{10'h0FA, 10'h305, 10'h0FA, 10'h305};
        for (int w = 0; w < 4; w++) begin
            drive_word(words[w], 1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) begin
                next_bit(e, o);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL back_to_back w%0d bit%0d: got %b required %b", w, i, o, e);
                end
            end
        end
        $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_disparity();
        logic [3:0] e, o;
        logic [9:0] words[4] = '{10'h0FA, 10'h0FA, 10'h3FF, 10'h305};
        logic       errs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int w = 0; w < 4; w++) begin
            drive_word(words[w], 1'b1, 1'b0, 1'b0, errs[w]);
            for (int i = 0; i < 10; i++) begin
                next_bit(e, o);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL disparity w%0d bit%0d: got %b required %b", w, i, o, e);
                end
            end
        end
        $display("test_disparity done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_idle_polarity();
        logic [3:0] e, o;
        // Leaves rd at RD+, so a missing RD- restart after idle shows up as Disp_Err.
        drive_word(10'h0FA, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            next_bit(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL idle_midword bit%0d: got %b required %b", i, o, e);
            end
            if (i == 3) TxElecIdle = 1'b1;
        end
        drive_word(10'h0FA, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            next_bit(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL idle_word bit%0d: got %b required %b", i, o, e);
            end
        end
        drive_word(10'h0FA, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            next_bit(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL polarity bit%0d: got %b required %b", i, o, e);
            end
            if (i == 4) Tx_Polarity = 1'b0;
        end
        $display("test_idle_polarity done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_midword();
        logic [3:0] e, o;
        drive_word(10'h305, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 5; i++) begin
            next_bit(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_midword bit%0d: got %b required %b", i, o, e);
            end
        end
        Reset_n = 1'b0;
        Data_Valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            o = {TX_Out, TX_Idle, Word_Start, Disp_Err};
            checks++;
            if (o !== 4'b0100) begin
                errors++;
                $display("FAIL reset_midword_hold cycle%0d: got %b required 0100", i, o);
            end
        end
        Reset_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            o = {TX_Out, TX_Idle, Word_Start, Disp_Err};
            checks++;
            if (o !== 4'b0100) begin
                errors++;
                $display("FAIL reset_midword_release cycle%0d: got %b required 0100", i, o);
            end
        end
        drive_word(10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            next_bit(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_midword_first_word bit%0d: got %b required %b", i, o, e);
            end
        end
        $display("test_reset_midword done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_disparity();
        test_idle_polarity();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
